// File: rtl/femto_demux_pkg.sv
// Shared channel encodings and default widths for the 1:4 buffered demux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package femto_demux_pkg;

    localparam int N_DEFAULT     = 32;
    localparam int DEPTH_DEFAULT = 2;
    localparam int NUM_CH        = 4;
    localparam int OCC_W         = 3;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } chan_e;

    function automatic logic [NUM_CH-1:0] chan_decode(input logic [1:0] s);
        logic [NUM_CH-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO (DEPTH 2 or 4) with registered head, no data reset.
// Latency: a push is visible at dout/count one cycle later.
// Backpressure: push while full is accepted only together with a pop.
module demux_chan_fifo
    import femto_demux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [N-1:0]     din,
    output logic [N-1:0]     dout,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    localparam int PW = (DEPTH > 2) ? 2 : 1;

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/one_four_demux_buf.sv
// Routes one input word stream into four independently drained channel FIFOs.
// Latency: one cycle from accepted push to out_valid; no data bypass.
// Backpressure: in_ready follows fullness of the selected channel, allowing pop-and-push when full.
module one_four_demux_buf
    import femto_demux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [N-1:0]            in_data,
    input  logic [1:0]              sel,
    output logic                    in_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [N-1:0]            out_a,
    output logic [N-1:0]            out_b,
    output logic [N-1:0]            out_c,
    output logic [N-1:0]            out_d,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*OCC_W-1:0] occ
);

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [N-1:0]      dout  [NUM_CH];
    logic [OCC_W-1:0]  count [NUM_CH];

    // A full channel can still take a word if its head leaves on the same edge.
    assign in_ready  = ~full[sel] | (out_ready[sel] & ~empty[sel]);
    assign push      = chan_decode(sel) & {NUM_CH{in_valid & in_ready}};
    assign pop       = out_ready & ~empty;
    assign out_valid = ~empty;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data),
            .dout  (dout[k]),
            .count (count[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    assign out_a = dout[CH_A];
    assign out_b = dout[CH_B];
    assign out_c = dout[CH_C];
    assign out_d = dout[CH_D];
    assign occ   = {count[CH_D], count[CH_C], count[CH_B], count[CH_A]};

endmodule

// File: tb/tb_one_four_demux_buf.sv
// Directed and scoreboard-driven checks of the 1:4 demux buffer at DEPTH 2 and DEPTH 4.
module tb_one_four_demux_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic [3:0]  out_ready;

    logic        ir2, ir4;
    logic [3:0]  ov2, ov4;
    logic [31:0] oa2, ob2, oc2_, od2, oa4, ob4, oc4_, od4;
    logic [11:0] occ2, occ4;

    logic        ir [2];
    logic [3:0]  ov [2];
    logic [11:0] oc [2];
    logic [31:0] hd [8];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq [8][$];
    int          dp [2];

    always #5 clk = ~clk;

    one_four_demux_buf #(.N(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .sel(sel),
        .in_ready(ir2), .out_valid(ov2), .out_a(oa2), .out_b(ob2), .out_c(oc2_), .out_d(od2),
        .out_ready(out_ready), .occ(occ2)
    );

    one_four_demux_buf #(.N(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .sel(sel),
        .in_ready(ir4), .out_valid(ov4), .out_a(oa4), .out_b(ob4), .out_c(oc4_), .out_d(od4),
        .out_ready(out_ready), .occ(occ4)
    );

    assign ir[0] = ir2;  assign ir[1] = ir4;
    assign ov[0] = ov2;  assign ov[1] = ov4;
    assign oc[0] = occ2; assign oc[1] = occ4;
    assign hd[0] = oa2;  assign hd[1] = ob2; assign hd[2] = oc2_; assign hd[3] = od2;
    assign hd[4] = oa4;  assign hd[5] = ob4; assign hd[6] = oc4_; assign hd[7] = od4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = 2'd0; out_ready = 4'd0;
        #3;
        n_cmp++; if (ov2 !== 4'b0000) begin n_bad++; $display("FAIL reset_ov2 got %b exp 0000", ov2); end
        n_cmp++; if (occ2 !== 12'd0) begin n_bad++; $display("FAIL reset_occ2 got %h exp 000", occ2); end
        n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL reset_ir2 got %b exp 1", ir2); end
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL reset_ov4 got %b exp 0000", ov4); end
        n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL reset_ir4 got %b exp 1", ir4); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL post_reset_ir2 got %b exp 1", ir2); end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; sel = 2'b10; in_data = 32'h1111_1111; out_ready = 4'b0000;
        #1;
        n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL single_ir got %b exp 1", ir2); end
        n_cmp++; if (ov2 !== 4'b0000) begin n_bad++; $display("FAIL single_nobypass got %b exp 0000", ov2); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (ov2 !== 4'b0100) begin n_bad++; $display("FAIL single_ov got %b exp 0100", ov2); end
        n_cmp++; if (oc2_ !== 32'h1111_1111) begin n_bad++; $display("FAIL single_out_c got %h exp 11111111", oc2_); end
        n_cmp++; if (occ2 !== 12'b001_000_000) begin n_bad++; $display("FAIL single_occ got %h exp 040", occ2); end
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        n_cmp++; if (ov2 !== 4'b0000) begin n_bad++; $display("FAIL single_drain got %b exp 0000", ov2); end
    endtask

    task automatic test_full();
        in_valid = 1'b1; sel = 2'b00; out_ready = 4'b0000; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_data = 32'hA9;
        #1;
        n_cmp++; if (occ2[2:0] !== 3'd2) begin n_bad++; $display("FAIL full_occ got %0d exp 2", occ2[2:0]); end
        n_cmp++; if (ir2 !== 1'b0) begin n_bad++; $display("FAIL full_ir_a got %b exp 0", ir2); end
        n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL full_ir_a_depth4 got %b exp 1", ir4); end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (ir2 !== 1'b0) begin n_bad++; $display("FAIL full_ir_novalid got %b exp 0", ir2); end
        sel = 2'b01;
        #1;
        n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL full_ir_b got %b exp 1", ir2); end
    endtask

    task automatic test_pop_push_full();
        in_valid = 1'b1; sel = 2'b00; in_data = 32'hA2; out_ready = 4'b0001;
        #1;
        n_cmp++; if (ir2 !== 1'b1) begin n_bad++; $display("FAIL pp_ir got %b exp 1", ir2); end
        n_cmp++; if (oa2 !== 32'hA0) begin n_bad++; $display("FAIL pp_head0 got %h exp a0", oa2); end
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        n_cmp++; if (oa2 !== 32'hA1) begin n_bad++; $display("FAIL pp_head1 got %h exp a1", oa2); end
        n_cmp++; if (occ2[2:0] !== 3'd2) begin n_bad++; $display("FAIL pp_occ got %0d exp 2", occ2[2:0]); end
        out_ready = 4'b0001;
        tick();
        n_cmp++; if (oa2 !== 32'hA2) begin n_bad++; $display("FAIL pp_head2 got %h exp a2", oa2); end
        n_cmp++; if (occ2[2:0] !== 3'd1) begin n_bad++; $display("FAIL pp_occ1 got %0d exp 1", occ2[2:0]); end
        tick();
        out_ready = 4'b0000;
        n_cmp++; if (ov2[0] !== 1'b0) begin n_bad++; $display("FAIL pp_empty got %b exp 0", ov2[0]); end
    endtask

    task automatic test_cross_channel();
        in_valid = 1'b1; out_ready = 4'b0000;
        sel = 2'b01; in_data = 32'hB0; tick();
        sel = 2'b10; in_data = 32'hC0; tick();
        sel = 2'b11; in_data = 32'hD0; tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (ov2 !== 4'b1110) begin n_bad++; $display("FAIL xch_ov got %b exp 1110", ov2); end
        n_cmp++; if (ob2 !== 32'hB0) begin n_bad++; $display("FAIL xch_b got %h exp b0", ob2); end
        n_cmp++; if (oc2_ !== 32'hC0) begin n_bad++; $display("FAIL xch_c got %h exp c0", oc2_); end
        n_cmp++; if (od2 !== 32'hD0) begin n_bad++; $display("FAIL xch_d got %h exp d0", od2); end
        n_cmp++; if (occ2 !== 12'b001_001_001_000) begin n_bad++; $display("FAIL xch_occ got %h exp 248", occ2); end
        out_ready = 4'b1111;
        tick();
        n_cmp++; if (occ2 !== 12'd0) begin n_bad++; $display("FAIL xch_drain_occ got %h exp 000", occ2); end
        n_cmp++; if (ov2 !== 4'b0000) begin n_bad++; $display("FAIL xch_drain_ov got %b exp 0000", ov2); end
        tick();
        out_ready = 4'b0000;
        n_cmp++; if (occ2 !== 12'd0) begin n_bad++; $display("FAIL xch_empty_pop got %h exp 000", occ2); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; sel = 2'b11; out_ready = 4'b0000;
        in_data = 32'hD0; tick();
        in_data = 32'hD1; tick();
        in_data = 32'hD2; tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (occ4[11:9] !== 3'd3) begin n_bad++; $display("FAIL ar_occ_pre got %0d exp 3", occ4[11:9]); end
        n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL ar_ir_pre got %b exp 1", ir4); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL ar_ov got %b exp 0000", ov4); end
        n_cmp++; if (occ4 !== 12'd0) begin n_bad++; $display("FAIL ar_occ got %h exp 000", occ4); end
        n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL ar_ir got %b exp 1", ir4); end
        n_cmp++; if (occ2 !== 12'd0) begin n_bad++; $display("FAIL ar_occ2 got %h exp 000", occ2); end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random_traffic();
        logic exp_rdy [2];
        int   idx;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 4'd0;
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) mq[i].delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            #1;
            for (int d = 0; d < 2; d++) begin
                idx        = d * 4 + int'(sel);
                exp_rdy[d] = (mq[idx].size() < dp[d]) || (out_ready[sel] && mq[idx].size() != 0);
                n_cmp++;
                if (ir[d] !== exp_rdy[d]) begin
                    n_bad++; $display("FAIL rnd_ready dut%0d cyc %0d got %b exp %b", dp[d], c, ir[d], exp_rdy[d]);
                end
                for (int k = 0; k < 4; k++) begin
                    idx = d * 4 + k;
                    n_cmp++;
                    if (oc[d][k*3 +: 3] !== 3'(mq[idx].size())) begin
                        n_bad++; $display("FAIL rnd_occ dut%0d ch%0d cyc %0d got %0d exp %0d", dp[d], k, c, oc[d][k*3 +: 3], mq[idx].size());
                    end
                    n_cmp++;
                    if (ov[d][k] !== (mq[idx].size() != 0)) begin
                        n_bad++; $display("FAIL rnd_valid dut%0d ch%0d cyc %0d got %b", dp[d], k, c, ov[d][k]);
                    end
                    if (mq[idx].size() != 0) begin
                        n_cmp++;
                        if (hd[idx] !== mq[idx][0]) begin
                            n_bad++; $display("FAIL rnd_head dut%0d ch%0d cyc %0d got %h exp %h", dp[d], k, c, hd[idx], mq[idx][0]);
                        end
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    if (out_ready[k] && mq[d*4+k].size() != 0) void'(mq[d*4+k].pop_front());
                end
                if (in_valid && exp_rdy[d]) mq[d*4+int'(sel)].push_back(in_data);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 4'd0;
    endtask

    initial begin
        dp[0] = 2;
        dp[1] = 4;
        test_reset();
        test_single_push();
        test_full();
        test_pop_push_full();
        test_cross_channel();
        test_async_reset();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/one_four_demux_buf.md
ONE_FOUR_DEMUX_BUF -- requirements
Module: one_four_demux_buf

Interface
REQ-001 Parameter N, default 32: data width of the input and of each output channel.
REQ-002 Parameter DEPTH, default 2: entries per channel buffer; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  producer offers in_data for channel sel.
REQ-006 in_data  input  N  word to route.
REQ-007 sel  input  2  destination channel: 00=A, 01=B, 10=C, 11=D.
REQ-008 in_ready  output  1  module accepts the offered word this cycle.
REQ-009 out_valid  output  4  per-channel word available; bit 0=A ... bit 3=D.
REQ-010 out_a, out_b, out_c, out_d  output  N each  head word of each channel buffer.
REQ-011 out_ready  input  4  per-channel consumer takes the head word; bit 0=A ... bit 3=D.
REQ-012 occ  output  4x3 packed (12)  per-channel entry count, channel A in bits [2:0].

Function
REQ-013 A push occurs when in_valid and in_ready are both 1 on a rising edge; the word is written only into the buffer of channel sel.
REQ-014 in_ready SHALL be combinational: 1 when channel[sel] is not full, or when channel[sel] is full and out_ready[sel]=1 with out_valid[sel]=1 (pop-and-push in the same cycle).
REQ-015 in_ready SHALL NOT depend on in_valid.
REQ-016 A pop on channel k occurs when out_valid[k] and out_ready[k] are both 1 on a rising edge.
REQ-017 Latency: a word pushed into an empty channel appears with out_valid=1 on the cycle after the push; there is no combinational bypass from in_data to any output.
REQ-018 Each channel SHALL be FIFO-ordered; relative order across channels is not defined.
REQ-019 out_valid[k] SHALL equal (occ[k] != 0), and out_k SHALL equal the head entry; out_k is don't-care while out_valid[k]=0.
REQ-020 Simultaneous push and pop on the same channel: occ is unchanged, the head advances, and the new word is appended at the tail, including when the channel is full.
REQ-021 Simultaneous push into one channel and pops on any other channels SHALL all take effect in the same cycle.
REQ-022 Pointers wrap modulo DEPTH; occ ranges 0..DEPTH.
REQ-023 A pop request while out_valid[k]=0 is ignored.
REQ-024 When in_valid=0, sel and in_data are ignored.

Reset
REQ-025 On rst_n=0, all channels empty immediately (asynchronous): occ=0, out_valid=0000, pointers=0.
REQ-026 in_ready SHALL read 1 during and after reset, because every channel is empty.
REQ-027 Buffer data storage is not reset; out_a..out_d are don't-care after reset.
REQ-028 Reset asserted mid-operation discards all buffered words; no pop is reported for them.

Structure
REQ-029 Channel encodings (CH_A..CH_D), the default N and the default DEPTH SHALL live in shared package femto_demux_pkg.
REQ-030 One sub-module, demux_chan_fifo (parameters N and DEPTH; signals push, pop, din, dout, count, full, empty), SHALL be instantiated four times.
REQ-031 The top level SHALL contain only the sel decode, the in_ready select and the output packing.

Verification
REQ-032 Reset, then push 0x11111111 with sel=10 and out_ready=0000 -> next cycle out_valid=0100, out_c=0x11111111, occ C=1.
REQ-033 With DEPTH=2, push 0xA0 then 0xA1 to channel A with out_ready=0 -> occ A=2; a third offer to A gives in_ready=0, while an offer with sel=01 gives in_ready=1.
REQ-034 Channel A full, out_ready[0]=1, push 0xA2 with sel=00 -> in_ready=1; next cycle out_a=0xA1, occ A=2; the following pop returns 0xA2.
REQ-035 Push B=0xB0, C=0xC0, D=0xD0 on consecutive cycles, then set out_ready=1111 -> each word appears only on its own channel, and all occ return to 0 on the same edge.
REQ-036 Three words in channel D, DEPTH=4; assert rst_n=0 asynchronously between clock edges -> out_valid=0000 and occ=0 without waiting for a clock edge, and in_ready=1.
REQ-037 Random push/pop traffic for 10k cycles against a scoreboard of per-channel queues -> no loss, duplication or reordering, and occ always matches the scoreboard.
